// File: rtl/sample_read_sequencer.sv
// Read-address scheduler for the dual-port GPS I/Q sample store: a four-lane
// acquisition channel with setup/run/drain sequencing and an independent tracking stream.
module sample_read_sequencer #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32736
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acq_start,
  input  logic [ADDR_W-1:0] acq_base,
  input  logic [ADDR_W-1:0] acq_len,
  input  logic              acq_stall,
  input  logic              acq_abort,
  output logic [ADDR_W-1:0] rd_ptr1,
  output logic [ADDR_W-1:0] rd_ptr2,
  output logic [ADDR_W-1:0] rd_ptr3,
  output logic [ADDR_W-1:0] rd_ptr4,
  output logic              acq_valid,
  output logic              acq_busy,
  output logic              acq_done,
  output logic              acq_err,
  input  logic              trk_start,
  input  logic [ADDR_W-1:0] trk_base,
  input  logic [ADDR_W-1:0] trk_len,
  input  logic              trk_hold,
  output logic [ADDR_W-1:0] read_pointerT,
  output logic              trk_valid,
  output logic              trk_busy,
  output logic              trk_done
);

  // state    | meaning
  // A_IDLE   | waiting for acq_start
  // A_SETUP2 | rd_ptr2 = rd_ptr1 + L
  // A_SETUP3 | rd_ptr3 = rd_ptr2 + L
  // A_SETUP4 | rd_ptr4 = rd_ptr3 + L
  // A_RUN    | issuing one address per lane per unstalled cycle
  // A_DRAIN  | last read data in flight
  // T_IDLE   | tracking stream waiting for trk_start
  // T_RUN    | tracking stream issuing addresses

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LEN_MAX  = ADDR_W'(DEPTH / 4);

  typedef enum logic [2:0] {A_IDLE, A_SETUP2, A_SETUP3, A_SETUP4, A_RUN, A_DRAIN} acq_state_t;
  typedef enum logic {T_IDLE, T_RUN} trk_state_t;

  acq_state_t        acq_state, acq_next;
  trk_state_t        trk_state, trk_next;
  logic [ADDR_W-1:0] acq_len_q;
  logic [ADDR_W-1:0] acq_cnt;
  logic [ADDR_W-1:0] trk_cnt;
  logic              acq_accept, acq_reject, acq_issue, acq_last;
  logic              ld2, ld3, ld4;
  logic              trk_load, trk_issue, trk_last;
  logic              len_ok;

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] inc_ptr(input logic [ADDR_W-1:0] a);
    return (a == PTR_LAST) ? '0 : a + 1'b1;
  endfunction

  assign len_ok = (acq_len != '0) && (acq_len <= LEN_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      acq_state <= A_IDLE;
      trk_state <= T_IDLE;
    end else begin
      acq_state <= acq_next;
      trk_state <= trk_next;
    end
  end

  // Abort dominates every state, including a coincident start in A_IDLE.
  always_comb begin
    acq_next   = acq_state;
    acq_accept = 1'b0;
    acq_reject = 1'b0;
    acq_issue  = 1'b0;
    acq_last   = 1'b0;
    ld2        = 1'b0;
    ld3        = 1'b0;
    ld4        = 1'b0;
    if (acq_abort) begin
      acq_next = A_IDLE;
    end else begin
      case (acq_state)
        A_IDLE: begin
          if (acq_start) begin
            if (len_ok) begin
              acq_accept = 1'b1;
              acq_next   = A_SETUP2;
            end else begin
              acq_reject = 1'b1;
            end
          end
        end
        A_SETUP2: begin
          ld2      = 1'b1;
          acq_next = A_SETUP3;
        end
        A_SETUP3: begin
          ld3      = 1'b1;
          acq_next = A_SETUP4;
        end
        A_SETUP4: begin
          ld4      = 1'b1;
          acq_next = A_RUN;
        end
        A_RUN: begin
          if (!acq_stall) begin
            acq_issue = 1'b1;
            if (acq_cnt == ADDR_W'(1)) begin
              acq_last = 1'b1;
              acq_next = A_DRAIN;
            end
          end
        end
        A_DRAIN:  acq_next = A_IDLE;
        default:  acq_next = A_IDLE;
      endcase
    end
  end

  always_comb begin
    trk_next  = trk_state;
    trk_load  = 1'b0;
    trk_issue = 1'b0;
    trk_last  = 1'b0;
    case (trk_state)
      T_IDLE: begin
        if (trk_start && (trk_len != '0)) begin
          trk_load = 1'b1;
          trk_next = T_RUN;
        end
      end
      T_RUN: begin
        if (!trk_hold) begin
          trk_issue = 1'b1;
          if (trk_cnt == ADDR_W'(1)) begin
            trk_last = 1'b1;
            trk_next = T_IDLE;
          end
        end
      end
      default: trk_next = T_IDLE;
    endcase
  end

  assign acq_busy = (acq_state != A_IDLE);
  assign trk_busy = (trk_state == T_RUN);

  // acq_cnt counts remaining issues down to the terminal value 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr1   <= '0;
      rd_ptr2   <= '0;
      rd_ptr3   <= '0;
      rd_ptr4   <= '0;
      acq_len_q <= '0;
      acq_cnt   <= '0;
      acq_valid <= 1'b0;
      acq_done  <= 1'b0;
      acq_err   <= 1'b0;
    end else begin
      acq_valid <= acq_issue;
      acq_done  <= acq_last;
      acq_err   <= acq_reject;
      if (acq_accept) begin
        rd_ptr1   <= acq_base;
        acq_len_q <= acq_len;
        acq_cnt   <= acq_len;
      end
      if (ld2) rd_ptr2 <= wrap_add(rd_ptr1, acq_len_q);
      if (ld3) rd_ptr3 <= wrap_add(rd_ptr2, acq_len_q);
      if (ld4) rd_ptr4 <= wrap_add(rd_ptr3, acq_len_q);
      if (acq_issue) begin
        rd_ptr1 <= inc_ptr(rd_ptr1);
        rd_ptr2 <= inc_ptr(rd_ptr2);
        rd_ptr3 <= inc_ptr(rd_ptr3);
        rd_ptr4 <= inc_ptr(rd_ptr4);
        acq_cnt <= acq_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_pointerT <= '0;
      trk_cnt       <= '0;
      trk_valid     <= 1'b0;
      trk_done      <= 1'b0;
    end else begin
      trk_valid <= trk_issue;
      trk_done  <= trk_last;
      if (trk_load) begin
        read_pointerT <= trk_base;
        trk_cnt       <= trk_len;
      end else if (trk_issue) begin
        read_pointerT <= inc_ptr(read_pointerT);
        trk_cnt       <= trk_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_read_sequencer.sv
// Randomized bench for sample_read_sequencer; expected behaviour is derived from
// per-cycle issue schedules and modulo address arithmetic.
module tb_sample_read_sequencer;
  localparam int AW    = 15;
  localparam int DEPTH = 32736;
  localparam int MAXC  = 8400;

  logic          clk = 1'b0;
  logic          rst;
  logic          acq_start, acq_stall, acq_abort;
  logic [AW-1:0] acq_base, acq_len;
  logic [AW-1:0] rd_ptr1, rd_ptr2, rd_ptr3, rd_ptr4;
  logic          acq_valid, acq_busy, acq_done, acq_err;
  logic          trk_start, trk_hold;
  logic [AW-1:0] trk_base, trk_len;
  logic [AW-1:0] read_pointerT;
  logic          trk_valid, trk_busy, trk_done;

  always #5 clk = ~clk;

  sample_read_sequencer #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .acq_start(acq_start), .acq_base(acq_base), .acq_len(acq_len),
    .acq_stall(acq_stall), .acq_abort(acq_abort),
    .rd_ptr1(rd_ptr1), .rd_ptr2(rd_ptr2), .rd_ptr3(rd_ptr3), .rd_ptr4(rd_ptr4),
    .acq_valid(acq_valid), .acq_busy(acq_busy), .acq_done(acq_done), .acq_err(acq_err),
    .trk_start(trk_start), .trk_base(trk_base), .trk_len(trk_len), .trk_hold(trk_hold),
    .read_pointerT(read_pointerT),
    .trk_valid(trk_valid), .trk_busy(trk_busy), .trk_done(trk_done)
  );

  int    n_chk = 0;
  int    n_err = 0;
  int    cyc   = 0;
  string scen  = "reset";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s cycle %0d: got %0d expected %0d", scen, tag, cyc, got, exp);
    end
  endtask

  int abase, alen, abort_cyc, collide_cyc, ts, tbase, tlen, rst_cyc;
  bit stall_a [MAXC];
  bit hold_a  [MAXC];
  bit acq_is  [MAXC];
  bit trk_is  [MAXC];
  int acq_before [MAXC];
  int trk_before [MAXC];

  task automatic set_defaults(input string name);
    scen = name;
    abase = 0; alen = 0; abort_cyc = -1; collide_cyc = -1;
    ts = -1; tbase = 0; tlen = 0; rst_cyc = -1;
    for (int i = 0; i < MAXC; i++) begin
      stall_a[i] = 1'b0;
      hold_a[i]  = 1'b0;
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_ptr1", 32'(rd_ptr1), 0);
    chk("rst_ptr2", 32'(rd_ptr2), 0);
    chk("rst_ptr3", 32'(rd_ptr3), 0);
    chk("rst_ptr4", 32'(rd_ptr4), 0);
    chk("rst_ptrT", 32'(read_pointerT), 0);
    chk("rst_flags", {25'd0, acq_valid, acq_busy, acq_done, acq_err,
                      trk_valid, trk_busy, trk_done}, 0);
  endtask

  task automatic run_scen();
    bit accepted, rejected, completed, ttaken;
    int n, m, last, tlast, aend, tend, ncyc, k;
    accepted = (alen != 0) && (alen <= DEPTH / 4) && (abort_cyc != 0);
    rejected = !((alen != 0) && (alen <= DEPTH / 4)) && (abort_cyc != 0);
    ttaken   = (ts >= 0) && (tlen != 0);
    n = 0; m = 0; last = -1; tlast = -1;
    for (int c = 0; c < MAXC; c++) begin
      acq_before[c] = n;
      acq_is[c] = accepted && c >= 4 && n < alen && (abort_cyc < 0 || c < abort_cyc) && !stall_a[c];
      if (acq_is[c]) begin
        n++;
        if (n == alen) last = c;
      end
      trk_before[c] = m;
      trk_is[c] = ttaken && c >= ts + 1 && m < tlen && !hold_a[c];
      if (trk_is[c]) begin
        m++;
        if (m == tlen) tlast = c;
      end
    end
    completed = accepted && (n == alen);
    aend = !accepted ? 0 : (completed ? last + 2 : abort_cyc + 1);
    tend = ttaken ? tlast + 1 : 0;
    ncyc = ((aend > tend) ? aend : tend);
    if (ncyc < 8) ncyc = 8;
    ncyc = ncyc + 3;
    if (rst_cyc >= 0) ncyc = rst_cyc + 3;

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cyc = c;
      rst       = (c == rst_cyc);
      acq_start = (c == 0) || (c == collide_cyc);
      acq_base  = AW'(abase);
      acq_len   = (c == collide_cyc) ? '0 : AW'(alen);
      acq_stall = stall_a[c];
      acq_abort = (c == abort_cyc);
      trk_start = (c == ts);
      trk_base  = AW'(tbase);
      trk_len   = AW'(tlen);
      trk_hold  = hold_a[c];
      if (rst_cyc >= 0 && c > rst_cyc) begin
        chk_all_zero();
      end else begin
        chk("acq_busy",  32'(acq_busy),  32'(accepted && c >= 1 && c < aend));
        chk("acq_valid", 32'(acq_valid), 32'(c > 0 && acq_is[c > 0 ? c - 1 : 0]));
        chk("acq_done",  32'(acq_done),  32'(completed && c == last + 1));
        chk("acq_err",   32'(acq_err),   32'(rejected && c == 1));
        if (accepted && c >= 4 && c < aend && acq_before[c] < alen &&
            (abort_cyc < 0 || c <= abort_cyc)) begin
          k = acq_before[c];
          chk("rd_ptr1", 32'(rd_ptr1), (abase + k) % DEPTH);
          chk("rd_ptr2", 32'(rd_ptr2), (abase + alen + k) % DEPTH);
          chk("rd_ptr3", 32'(rd_ptr3), (abase + 2 * alen + k) % DEPTH);
          chk("rd_ptr4", 32'(rd_ptr4), (abase + 3 * alen + k) % DEPTH);
        end
        chk("trk_busy",  32'(trk_busy),  32'(ttaken && c >= ts + 1 && c < tend));
        chk("trk_valid", 32'(trk_valid), 32'(c > 0 && trk_is[c > 0 ? c - 1 : 0]));
        chk("trk_done",  32'(trk_done),  32'(ttaken && c == tlast + 1));
        if (ttaken && c >= ts + 1 && c <= tlast)
          chk("read_pointerT", 32'(read_pointerT), (tbase + trk_before[c]) % DEPTH);
      end
    end
    rst = 1'b0; acq_start = 1'b0; acq_stall = 1'b0; acq_abort = 1'b0;
    trk_start = 1'b0; trk_hold = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; acq_start = 1'b0; acq_base = '0; acq_len = '0; acq_stall = 1'b0;
    acq_abort = 1'b0; trk_start = 1'b0; trk_base = '0; trk_len = '0; trk_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero();
    rst = 1'b0;

    set_defaults("basic");   alen = 4; run_scen();
    set_defaults("wrap");    abase = 32734; alen = 3; run_scen();
    set_defaults("stall");   abase = 500; alen = 6; stall_a[6] = 1'b1; stall_a[7] = 1'b1; run_scen();
    set_defaults("len0");    abase = 7; alen = 0; run_scen();
    set_defaults("len8185"); abase = 7; alen = 8185; run_scen();
    set_defaults("abort_start"); abase = 9; alen = 5; abort_cyc = 0; run_scen();
    set_defaults("collide"); abase = 1234; alen = 8; collide_cyc = 6; run_scen();
    set_defaults("abort_trk");
    abase = 2000; alen = 8; abort_cyc = 5; ts = 0; tbase = 100; tlen = 10; run_scen();
    set_defaults("rst_trk");
    abase = 2000; alen = 8; ts = 0; tbase = 100; tlen = 10; rst_cyc = 6; run_scen();
    set_defaults("trk_len0"); ts = 1; tbase = 55; tlen = 0; alen = 2; abase = 32735; run_scen();
    set_defaults("len_max"); abase = $urandom_range(DEPTH - 1); alen = DEPTH / 4; run_scen();

    for (int i = 0; i < 30; i++) begin
      set_defaults("random");
      abase = $urandom_range(DEPTH - 1);
      r = $urandom_range(9);
      alen = (r == 0) ? 0 : ((r == 1) ? $urandom_range(32767, 8185) : $urandom_range(40, 1));
      for (int c = 0; c < 400; c++) stall_a[c] = ($urandom_range(3) == 0);
      if ($urandom_range(4) == 0) abort_cyc = $urandom_range(alen + 8, 1);
      if (abort_cyc < 0 && alen >= 1 && alen <= 40 && $urandom_range(2) == 0) collide_cyc = 5;
      if ($urandom_range(3) != 0) begin
        ts    = $urandom_range(5);
        tbase = $urandom_range(DEPTH - 1);
        tlen  = ($urandom_range(7) == 0) ? 0 : $urandom_range(30, 1);
        for (int c = 0; c < 400; c++) hold_a[c] = ($urandom_range(3) == 0);
      end
      run_scen();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
